// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : riscv_pkg
//  Description : Shared encodings for the execute stage: ALU control codes,
//                RV32M multiply/divide operations and the muldiv FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  // ALU control encodings used by the execute-stage ALU
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_ctrl_t;

  // RV32M operations, encoded as the instruction funct3 field
  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } muldiv_op_t;

  // Iterative multiply/divide unit states
  typedef enum logic [1:0] {
    MD_IDLE   = 2'd0,
    MD_ST_MUL = 2'd1,
    MD_ST_DIV = 2'd2,
    MD_DONE   = 2'd3
  } muldiv_state_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
//  Interface   : muldiv_unit_if
//  Description : Request / result handshake bundle between the execute stage
//                (master) and the iterative multiply/divide unit (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  Valid_i;
  logic                  Ready_o;
  logic [2:0]            Op_i;
  logic [DATA_WIDTH-1:0] SrcA_i;
  logic [DATA_WIDTH-1:0] SrcB_i;
  logic                  Flush_i;
  logic [DATA_WIDTH-1:0] Result_o;
  logic                  ResultValid_o;
  logic                  ResultReady_i;
  logic                  Busy_o;

  modport slave (
    input  Valid_i, Op_i, SrcA_i, SrcB_i, Flush_i, ResultReady_i,
    output Ready_o, Result_o, ResultValid_o, Busy_o
  );

  modport master (
    output Valid_i, Op_i, SrcA_i, SrcB_i, Flush_i, ResultReady_i,
    input  Ready_o, Result_o, ResultValid_o, Busy_o
  );
endinterface : muldiv_unit_if
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative RV32M multiply/divide unit. One shift-add
//                (multiply) or restoring-division step per cycle on operand
//                magnitudes, sign-corrected when the last step completes.
//                Divide-by-zero and signed overflow finish after one cycle.
//                A single adder/subtractor serves both step types.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,   // active-low asynchronous reset
  muldiv_unit_if.slave bus
);

  localparam int                  c_CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [c_CNT_W-1:0]  c_LAST  = c_CNT_W'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] c_MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  muldiv_state_t           r_state;
  muldiv_state_t           w_state_next;
  muldiv_op_t              r_op;
  logic [c_CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0]   r_opnd;    // multiplicand (MUL) or divisor (DIV) magnitude
  logic [DATA_WIDTH-1:0]   r_hi;      // product high half / partial remainder
  logic [DATA_WIDTH-1:0]   r_lo;      // multiplier / dividend shifting into quotient
  logic [DATA_WIDTH-1:0]   r_result;
  logic                    r_neg;     // negate product or quotient at finish
  logic                    r_rneg;    // negate remainder at finish
  logic                    r_ovf;     // signed overflow case latched at accept

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  muldiv_op_t              w_op_in;
  logic                    w_a_signed;
  logic                    w_b_signed;
  logic                    w_a_neg;
  logic                    w_b_neg;
  logic [DATA_WIDTH-1:0]   w_mag_a;
  logic [DATA_WIDTH-1:0]   w_mag_b;
  logic                    w_ovf_in;
  logic                    w_ready;
  logic                    w_accept;

  // Operand signedness and magnitudes for the incoming request
  always_comb begin
    w_op_in    = muldiv_op_t'(bus.Op_i);
    w_a_signed = (w_op_in inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
    w_b_signed = (w_op_in inside {MD_MULH, MD_DIV, MD_REM});
    w_a_neg    = w_a_signed && bus.SrcA_i[DATA_WIDTH-1];
    w_b_neg    = w_b_signed && bus.SrcB_i[DATA_WIDTH-1];
    w_mag_a    = w_a_neg ? -bus.SrcA_i : bus.SrcA_i;
    w_mag_b    = w_b_neg ? -bus.SrcB_i : bus.SrcB_i;
    w_ovf_in   = (w_op_in inside {MD_DIV, MD_REM}) &&
                 (bus.SrcA_i == c_MOST_NEG) && (bus.SrcB_i == '1);
  end

  assign w_ready  = (r_state == MD_IDLE) && !bus.Flush_i;
  assign w_accept = bus.Valid_i && w_ready;

  // --------------------------------------------------------------------------
  // Shared adder/subtractor: adds the multiplicand in MUL, subtracts the
  // divisor from the shifted partial remainder in DIV. Carry-out of the
  // subtraction means "no borrow", i.e. the trial subtraction succeeded.
  // --------------------------------------------------------------------------
  logic                    w_sub;
  logic [DATA_WIDTH:0]     w_add_a;
  logic [DATA_WIDTH:0]     w_add_b;
  logic [DATA_WIDTH+1:0]   w_sum;

  // Operand selection for the single adder
  always_comb begin
    w_sub   = (r_state == MD_ST_DIV);
    w_add_a = w_sub ? {r_hi, r_lo[DATA_WIDTH-1]} : {1'b0, r_hi};
    w_add_b = w_sub ? ~{1'b0, r_opnd} : {1'b0, r_opnd};
    w_sum   = {1'b0, w_add_a} + {1'b0, w_add_b} + {{(DATA_WIDTH+1){1'b0}}, w_sub};
  end

  // --------------------------------------------------------------------------
  // Step results and final sign correction
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH:0]       w_mul_acc;
  logic [DATA_WIDTH-1:0]     w_mul_hi_next;
  logic [DATA_WIDTH-1:0]     w_mul_lo_next;
  logic                      w_div_ok;
  logic [DATA_WIDTH-1:0]     w_div_hi_next;
  logic [DATA_WIDTH-1:0]     w_div_lo_next;
  logic [2*DATA_WIDTH-1:0]   w_prod;
  logic [2*DATA_WIDTH-1:0]   w_prod_fix;
  logic [DATA_WIDTH-1:0]     w_quo;
  logic [DATA_WIDTH-1:0]     w_rem;
  logic                      w_is_rem;
  logic [DATA_WIDTH-1:0]     w_mul_result;
  logic [DATA_WIDTH-1:0]     w_div_result;
  logic [DATA_WIDTH-1:0]     w_byp_result;
  logic                      w_last;
  logic                      w_div_bypass;

  // Next iteration values and the result each finishing path would produce
  always_comb begin
    // shift-add: add multiplicand when the multiplier LSB is set, then shift right
    w_mul_acc     = r_lo[0] ? w_sum[DATA_WIDTH:0] : {1'b0, r_hi};
    w_mul_hi_next = w_mul_acc[DATA_WIDTH:1];
    w_mul_lo_next = {w_mul_acc[0], r_lo[DATA_WIDTH-1:1]};

    // restoring division: keep the difference only when it did not borrow
    w_div_ok      = w_sum[DATA_WIDTH+1];
    w_div_hi_next = w_div_ok ? w_sum[DATA_WIDTH-1:0]
                             : {r_hi[DATA_WIDTH-2:0], r_lo[DATA_WIDTH-1]};
    w_div_lo_next = {r_lo[DATA_WIDTH-2:0], w_div_ok};

    w_prod        = {w_mul_hi_next, w_mul_lo_next};
    w_prod_fix    = r_neg ? -w_prod : w_prod;
    w_mul_result  = (r_op == MD_MUL) ? w_prod_fix[DATA_WIDTH-1:0]
                                     : w_prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];

    w_is_rem      = (r_op inside {MD_REM, MD_REMU});
    w_quo         = r_neg  ? -w_div_lo_next : w_div_lo_next;
    w_rem         = r_rneg ? -w_div_hi_next : w_div_hi_next;
    w_div_result  = w_is_rem ? w_rem : w_quo;

    // r_lo still holds |A| before the first step. Zero divisor: quotient is
    // all ones, remainder is A itself. Overflow: quotient is A, remainder 0.
    if (r_opnd == '0) begin
      w_byp_result = w_is_rem ? (r_rneg ? -r_lo : r_lo) : '1;
    end else begin
      w_byp_result = w_is_rem ? '0 : r_lo;
    end

    w_last       = (r_cnt == c_LAST);
    w_div_bypass = (r_cnt == '0) && ((r_opnd == '0) || r_ovf);
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= MD_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; flush overrides everything, including accept
  always_comb begin
    w_state_next = r_state;
    if (bus.Flush_i) begin
      w_state_next = MD_IDLE;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (w_accept) begin
            w_state_next = bus.Op_i[2] ? MD_ST_DIV : MD_ST_MUL;
          end
        end
        MD_ST_MUL: begin
          if (w_last) begin
            w_state_next = MD_DONE;
          end
        end
        MD_ST_DIV: begin
          if (w_div_bypass || w_last) begin
            w_state_next = MD_DONE;
          end
        end
        MD_DONE: begin
          if (bus.ResultReady_i) begin
            w_state_next = MD_IDLE;
          end
        end
        default: w_state_next = MD_IDLE;
      endcase
    end
  end

  // Datapath: latch request, iterate, capture the sign-corrected result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op     <= MD_MUL;
      r_cnt    <= '0;
      r_opnd   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_result <= '0;
      r_neg    <= 1'b0;
      r_rneg   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (bus.Flush_i) begin
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (w_accept) begin
            r_op   <= w_op_in;
            r_cnt  <= '0;
            r_hi   <= '0;
            r_neg  <= w_a_neg ^ w_b_neg;
            r_rneg <= w_a_neg;
            r_ovf  <= w_ovf_in;
            if (bus.Op_i[2]) begin
              r_opnd <= w_mag_b;
              r_lo   <= w_mag_a;
            end else begin
              r_opnd <= w_mag_a;
              r_lo   <= w_mag_b;
            end
          end
        end
        MD_ST_MUL: begin
          r_hi  <= w_mul_hi_next;
          r_lo  <= w_mul_lo_next;
          r_cnt <= r_cnt + c_CNT_W'(1);
          if (w_last) begin
            r_result <= w_mul_result;
          end
        end
        MD_ST_DIV: begin
          if (w_div_bypass) begin
            r_result <= w_byp_result;
          end else begin
            r_hi  <= w_div_hi_next;
            r_lo  <= w_div_lo_next;
            r_cnt <= r_cnt + c_CNT_W'(1);
            if (w_last) begin
              r_result <= w_div_result;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.Ready_o       = w_ready;
  assign bus.ResultValid_o = (r_state == MD_DONE);
  assign bus.Busy_o        = (r_state != MD_IDLE);
  assign bus.Result_o      = r_result;

endmodule : muldiv_unit
`default_nettype wire
